// File: rtl/regfile_write_arbiter_if.sv
// Bundle of signals between the register-file write arbiter and its neighbours:
// WB and LLU write requests, LLU issue tracking, and the shared write port.
interface regfile_write_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             wb_valid;
  logic [4:0]       wb_reg;
  logic [31:0]      wb_data;
  logic             llu_valid;
  logic             llu_ready;
  logic [4:0]       llu_reg;
  logic [31:0]      llu_data;
  logic             issue_valid;
  logic [4:0]       issue_reg;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             pipe_stall;
  logic [31:0]      pending_mask;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output wb_valid, wb_reg, wb_data, llu_valid, llu_reg, llu_data,
           issue_valid, issue_reg,
    input  llu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pending_mask,
           fifo_count
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, llu_valid, llu_reg, llu_data,
           issue_valid, issue_reg,
    output llu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pending_mask,
           fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB and a buffered
// LLU result queue, with a starvation guard and LLU in-flight register tracking.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [STV_W-1:0] LIMIT_C  = STV_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [31:0]      pending_q, pending_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic   fifo_nonempty, starve, grant_fifo, grant_wb, push;
  entry_t head, grant_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant and stall are derived from registered state; only the NORMAL-mode
  // choice between WB and FIFO looks at wb_valid.
  assign head          = fifo_q[rd_ptr_q];
  assign fifo_nonempty = (count_q != '0);
  assign starve        = fifo_nonempty && (starve_q == LIMIT_C);
  assign grant_fifo    = starve || (!bus.wb_valid && fifo_nonempty);
  assign grant_wb      = !starve && bus.wb_valid;
  // A pop in the same cycle does not free a slot for a push.
  assign bus.llu_ready = !reset && (count_q < DEPTH_C);
  assign push          = bus.llu_valid && bus.llu_ready;
  assign grant_entry   = grant_fifo ? head : '{rd: bus.wb_reg, data: bus.wb_data};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pending_d  = pending_q;
    starve_d   = starve_q;

    if ((grant_fifo || grant_wb) && !(ZERO_PROTECT && grant_entry.rd == 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = grant_entry.rd;
      rf_wdata_d = grant_entry.data;
    end

    // Clear before set so a same-cycle re-issue of the popped register wins.
    if (grant_fifo) pending_d[head.rd] = 1'b0;
    if (bus.issue_valid && bus.issue_reg != 5'd0) pending_d[bus.issue_reg] = 1'b1;

    if (!fifo_nonempty || grant_fifo) starve_d = '0;
    else if (starve_q != LIMIT_C)     starve_d = starve_q + STV_W'(1);

    count_d  = count_q + CNT_W'(push) - CNT_W'(grant_fifo);
    rd_ptr_d = grant_fifo ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: queue storage has no reset; an entry is only read once count_q
  // says it was written, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rd: bus.llu_reg, data: bus.llu_data};
  end

  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pipe_stall   = starve;
  assign bus.pending_mask = pending_q;
  assign bus.fifo_count   = count_q;
endmodule
